// File: rtl/wb_regfile_stage.sv
// Write Back stage and architectural register file: result select, commit to a
// 16-entry register file, bypassed decode reads, retire counter and commit trace.
module wb_regfile_stage #(
   parameter int DATA_W    = 32,
   parameter int NUM_REGS  = 16,
   parameter int ADDR_W    = 4,
   parameter int PC_OFFSET = 8,
   parameter int CNT_W     = 32
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              wb_enable,
   input  logic              valid_in,
   input  logic [DATA_W-1:0] pc_in,
   input  logic [DATA_W-1:0] alu_result_in,
   input  logic [DATA_W-1:0] mem_read_data_in,
   input  logic [ADDR_W-1:0] rd_in,
   input  logic [4:0]        opcode_in,
   input  logic              reg_write_en_in,
   input  logic              mem_to_reg_in,
   input  logic [ADDR_W-1:0] ra1,
   input  logic [ADDR_W-1:0] ra2,
   input  logic [DATA_W-1:0] read_pc,
   output logic [DATA_W-1:0] rd1,
   output logic [DATA_W-1:0] rd2,
   output logic [DATA_W-1:0] wb_data,
   output logic              commit_q,
   output logic [ADDR_W-1:0] commit_rd_q,
   output logic [DATA_W-1:0] commit_data_q,
   output logic [4:0]        commit_opcode_q,
   output logic [CNT_W-1:0]  retired_count,
   output logic [DATA_W-1:0] last_retired_pc
);

   localparam logic [ADDR_W-1:0] PC_REG = ADDR_W'(NUM_REGS - 1);

   logic [DATA_W-1:0] regs_q [NUM_REGS];
   logic [DATA_W-1:0] regs_d [NUM_REGS];
   logic [CNT_W-1:0]  retired_count_q, retired_count_d;
   logic [DATA_W-1:0] last_pc_q, last_pc_d;
   logic              commit_d;
   logic [ADDR_W-1:0] commit_rd_d;
   logic [DATA_W-1:0] commit_data_d;
   logic [4:0]        commit_opcode_d;

   logic              commit;
   logic              retire;
   logic              bypass_ok;
   logic [DATA_W-1:0] pc_view;

   always_comb begin
      wb_data   = mem_to_reg_in ? mem_read_data_in : alu_result_in;
      retire    = wb_enable & valid_in;
      commit    = retire & reg_write_en_in & (rd_in != PC_REG);
      // The array is held cleared during reset, so the bypass must be too.
      bypass_ok = commit & ~reset;
      pc_view   = read_pc + DATA_W'(PC_OFFSET);
   end

   always_comb begin
      if (ra1 == PC_REG) begin
         rd1 = pc_view;
      end else if (bypass_ok && (ra1 == rd_in)) begin
         rd1 = wb_data;
      end else begin
         rd1 = regs_q[ra1];
      end
   end

   always_comb begin
      if (ra2 == PC_REG) begin
         rd2 = pc_view;
      end else if (bypass_ok && (ra2 == rd_in)) begin
         rd2 = wb_data;
      end else begin
         rd2 = regs_q[ra2];
      end
   end

   always_comb begin
      regs_d          = regs_q;
      retired_count_d = retired_count_q;
      last_pc_d       = last_pc_q;
      commit_d        = commit;
      commit_rd_d     = commit_rd_q;
      commit_data_d   = commit_data_q;
      commit_opcode_d = commit_opcode_q;
      if (commit) begin
         regs_d[rd_in]   = wb_data;
         commit_rd_d     = rd_in;
         commit_data_d   = wb_data;
         commit_opcode_d = opcode_in;
      end
      if (retire) begin
         retired_count_d = retired_count_q + CNT_W'(1);
         last_pc_d       = pc_in;
      end
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         regs_q          <= '{default: '0};
         retired_count_q <= '0;
         last_pc_q       <= '0;
         commit_q        <= 1'b0;
         commit_rd_q     <= '0;
         commit_data_q   <= '0;
         commit_opcode_q <= '0;
      end else begin
         regs_q          <= regs_d;
         retired_count_q <= retired_count_d;
         last_pc_q       <= last_pc_d;
         commit_q        <= commit_d;
         commit_rd_q     <= commit_rd_d;
         commit_data_q   <= commit_data_d;
         commit_opcode_q <= commit_opcode_d;
      end
   end

   assign retired_count   = retired_count_q;
   assign last_retired_pc = last_pc_q;

endmodule
